// File: rtl/rattlesnake_indirect_pointer_monitor.sv
// Detects the chained-load / aux-load / store-through-pointer overwrite pattern on the retiring stream.
// Flag is registered (1 cycle after the store); no backpressure, observes exe_enable only.
module rattlesnake_indirect_pointer_monitor #(
  parameter int          XLEN          = 32,
  parameter int          EXT_BITS      = 1,
  parameter int          MEM_ADDR_BITS = 16,
  parameter logic [4:0]  BASE_REG      = 5'd8,
  parameter int          DEREF_DEPTH   = 2,
  parameter int          MAX_GAP       = 2,
  parameter int          CNT_BITS      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sync_reset,
  input  logic                       exe_enable,
  input  logic                       exception_handler_active,
  input  logic [XLEN-1:0]            IR_in,
  input  logic [EXT_BITS+XLEN-1:0]   rs1_in_copy,
  input  logic [EXT_BITS+XLEN-1:0]   rs2_in_copy,
  input  logic [1:0]                 mode_sel,
  input  logic [MEM_ADDR_BITS-1:0]   mem_addr_blk_wr_start,
  input  logic [MEM_ADDR_BITS-1:0]   mem_addr_blk_wr_end,
  input  logic                       clear_stats,
  output logic                       indirect_protect_active,
  output logic                       protect_sticky,
  output logic [CNT_BITS-1:0]        detect_count,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, DEREF = 2'd1, AUX = 2'd2, STORE = 2'd3} state_t;

  localparam logic [2:0] DEPTH = 3'(DEREF_DEPTH);
  localparam logic [3:0] GAP   = 4'(MAX_GAP);

  state_t     state, state_nx;
  logic [4:0] rd_save, rd_save_nx, rd_aux_save, rd_aux_nx;
  logic [2:0] depth_cnt, depth_nx;
  logic [3:0] gap_cnt, gap_nx;
  logic       hit, match;

  logic [4:0] op5, rd, rs1, rs2;
  logic [2:0] funct3;
  logic       v, is_lw, is_sw, writes_rd;
  logic [XLEN-1:0]          s_imm, target;
  logic [MEM_ADDR_BITS-1:0] addr;
  logic       range_hit, tag_hit, mode_hit;

  assign op5    = IR_in[6:2];
  assign rd     = IR_in[11:7];
  assign funct3 = IR_in[14:12];
  assign rs1    = IR_in[19:15];
  assign rs2    = IR_in[24:20];
  assign v      = exe_enable & ~exception_handler_active;
  assign is_lw  = (IR_in[1:0] == 2'b11) && (op5 == 5'b00000) && (funct3 == 3'b010);
  assign is_sw  = (IR_in[1:0] == 2'b11) && (op5 == 5'b01000) && (funct3 == 3'b010);

  always_comb begin
    case (op5)
      5'b00000, 5'b00100, 5'b00101, 5'b01100,
      5'b01101, 5'b11001, 5'b11011: writes_rd = (rd != 5'd0);
      default:                      writes_rd = 1'b0;
    endcase
  end

  assign s_imm     = {{(XLEN-12){IR_in[31]}}, IR_in[31:25], IR_in[11:7]};
  assign target    = rs1_in_copy[XLEN-1:0] + s_imm;
  assign addr      = target[MEM_ADDR_BITS:1];
  assign range_hit = (mem_addr_blk_wr_start < mem_addr_blk_wr_end) &&
                     (mem_addr_blk_wr_start <= addr) && (addr < mem_addr_blk_wr_end);
  assign tag_hit   = rs1_in_copy[XLEN] | rs2_in_copy[XLEN];

  always_comb begin
    case (mode_sel)
      2'd0:    mode_hit = tag_hit;
      2'd1:    mode_hit = range_hit;
      2'd2:    mode_hit = tag_hit | range_hit;
      default: mode_hit = tag_hit & range_hit;
    endcase
  end

  always_comb begin
    state_nx   = state;
    rd_save_nx = rd_save;
    rd_aux_nx  = rd_aux_save;
    depth_nx   = depth_cnt;
    gap_nx     = gap_cnt;
    hit        = 1'b0;
    match      = 1'b0;
    if (sync_reset) begin
      state_nx = IDLE;
      depth_nx = '0;
      gap_nx   = '0;
    end else if (v) begin
      case (state)
        IDLE: if (is_lw && rs1 == BASE_REG) begin
          rd_save_nx = rd;
          depth_nx   = 3'd1;
          gap_nx     = '0;
          state_nx   = (DEPTH == 3'd1) ? AUX : DEREF;
        end
        DEREF: if (is_lw && rs1 == rd_save) begin
          match      = 1'b1;
          rd_save_nx = rd;
          depth_nx   = depth_cnt + 3'd1;
          gap_nx     = '0;
          if (depth_cnt + 3'd1 == DEPTH) state_nx = AUX;
        end
        AUX: if (is_lw && rs1 == BASE_REG && rd != rd_save) begin
          match     = 1'b1;
          rd_aux_nx = rd;
          gap_nx    = '0;
          state_nx  = STORE;
        end
        default: if (is_sw && rs1 == rd_save && rs2 == rd_aux_save) begin
          match    = 1'b1;
          hit      = mode_hit;
          state_nx = IDLE;
          depth_nx = '0;
          gap_nx   = '0;
        end
      endcase
      // Off-pattern instruction: a clobbered pointer/aux register kills the chain at once
      if (state != IDLE && !match) begin
        if ((writes_rd && rd == rd_save) ||
            (state == STORE && writes_rd && rd == rd_aux_save) || gap_cnt == GAP) begin
          state_nx = IDLE;
          depth_nx = '0;
          gap_nx   = '0;
        end else begin
          gap_nx = gap_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_save     <= '0;
      rd_aux_save <= '0;
      depth_cnt   <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nx;
      rd_save     <= rd_save_nx;
      rd_aux_save <= rd_aux_nx;
      depth_cnt   <= depth_nx;
      gap_cnt     <= gap_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      indirect_protect_active <= 1'b0;
      protect_sticky          <= 1'b0;
      detect_count            <= '0;
    end else begin
      if (exe_enable) indirect_protect_active <= hit;
      if (hit)              protect_sticky <= 1'b1;
      else if (clear_stats) protect_sticky <= 1'b0;
      if (hit) begin
        if (clear_stats)            detect_count <= CNT_BITS'(1);
        else if (~&detect_count)    detect_count <= detect_count + CNT_BITS'(1);
      end else if (clear_stats) begin
        detect_count <= '0;
      end
    end
  end

  assign state_dbg = state;

  logic unused_bits;
  assign unused_bits = ^{rs2_in_copy[XLEN-1:0], target[0], target[XLEN-1:MEM_ADDR_BITS+1]};

endmodule

// File: tb/tb_rattlesnake_indirect_pointer_monitor.sv
// Directed bench for the indirect-pointer monitor using the default parameter set.
module tb_rattlesnake_indirect_pointer_monitor;
  logic        clk = 1'b0;
  logic        reset_n, sync_reset, exe_enable, exception_handler_active, clear_stats;
  logic [31:0] IR_in;
  logic [32:0] rs1_in_copy, rs2_in_copy;
  logic [1:0]  mode_sel;
  logic [15:0] mem_addr_blk_wr_start, mem_addr_blk_wr_end;
  logic        indirect_protect_active, protect_sticky;
  logic [7:0]  detect_count;
  logic [1:0]  state_dbg;

  int tests  = 0;
  int errors = 0;

  localparam logic [31:0] LW1  = 32'h93042783;
  localparam logic [31:0] LW2  = 32'h0007a783;
  localparam logic [31:0] LW3  = 32'hea442703;
  localparam logic [31:0] SW   = 32'h00e7a023;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00478793;

  rattlesnake_indirect_pointer_monitor dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .exe_enable(exe_enable),
    .exception_handler_active(exception_handler_active), .IR_in(IR_in),
    .rs1_in_copy(rs1_in_copy), .rs2_in_copy(rs2_in_copy), .mode_sel(mode_sel),
    .mem_addr_blk_wr_start(mem_addr_blk_wr_start), .mem_addr_blk_wr_end(mem_addr_blk_wr_end),
    .clear_stats(clear_stats), .indirect_protect_active(indirect_protect_active),
    .protect_sticky(protect_sticky), .detect_count(detect_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic exec(input logic [31:0] ir, input logic [32:0] r1, input logic [32:0] r2,
                      input logic exc, input logic clr);
    IR_in = ir; rs1_in_copy = r1; rs2_in_copy = r2;
    exception_handler_active = exc; clear_stats = clr; exe_enable = 1'b1;
    @(posedge clk); #1;
    exe_enable = 1'b0; exception_handler_active = 1'b0; clear_stats = 1'b0; IR_in = NOP;
  endtask

  task automatic restart();
    sync_reset = 1'b1; @(posedge clk); #1; sync_reset = 1'b0;
  endtask

  task automatic clear();
    clear_stats = 1'b1; @(posedge clk); #1; clear_stats = 1'b0;
  endtask

  task automatic chain(input int g, input int gsw, input logic tag, input logic [31:0] base,
                       input logic clr_on_sw);
    exec(LW1, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < g; i++) exec(NOP, '0, '0, 1'b0, 1'b0);
    exec(LW2, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < g; i++) exec(NOP, '0, '0, 1'b0, 1'b0);
    exec(LW3, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < gsw; i++) exec(NOP, '0, '0, 1'b0, 1'b0);
    exec(SW, {1'b0, base}, {tag, 32'h0}, 1'b0, clr_on_sw);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", indirect_protect_active); end
    tests++; if (protect_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", protect_sticky); end
    tests++; if (detect_count !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", detect_count); end
    tests++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    reset_n = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_tag_mode();
    mode_sel = 2'd0; restart(); clear();
    chain(0, 0, 1'b1, 32'h0, 1'b0);
    tests++; if (indirect_protect_active !== 1'b1) begin errors++; $display("FAIL tag_flag got %b want 1", indirect_protect_active); end
    tests++; if (protect_sticky !== 1'b1) begin errors++; $display("FAIL tag_sticky got %b want 1", protect_sticky); end
    tests++; if (detect_count !== 8'h01) begin errors++; $display("FAIL tag_count got %h want 01", detect_count); end
    tests++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL tag_state got %0d want 0", state_dbg); end
    repeat (3) @(posedge clk); #1;
    tests++; if (indirect_protect_active !== 1'b1) begin errors++; $display("FAIL flag_hold got %b want 1", indirect_protect_active); end
    exec(NOP, '0, '0, 1'b0, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL flag_drop got %b want 0", indirect_protect_active); end
    chain(0, 0, 1'b0, 32'h0, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL tag_clear_flag got %b want 0", indirect_protect_active); end
    tests++; if (detect_count !== 8'h01) begin errors++; $display("FAIL tag_clear_count got %h want 01", detect_count); end
  endtask

  task automatic test_range_mode();
    mode_sel = 2'd1; restart(); clear();
    mem_addr_blk_wr_start = 16'h0800; mem_addr_blk_wr_end = 16'h0801;
    chain(0, 0, 1'b0, 32'h80001000, 1'b0);
    tests++; if (indirect_protect_active !== 1'b1) begin errors++; $display("FAIL range_flag got %b want 1", indirect_protect_active); end
    tests++; if (detect_count !== 8'h01) begin errors++; $display("FAIL range_count got %h want 01", detect_count); end
    mem_addr_blk_wr_end = 16'h0800;
    chain(0, 0, 1'b0, 32'h80001000, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL empty_flag got %b want 0", indirect_protect_active); end
    tests++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL empty_state got %0d want 0", state_dbg); end
    tests++; if (detect_count !== 8'h01) begin errors++; $display("FAIL empty_count got %h want 01", detect_count); end
  endtask

  task automatic test_mode_and();
    mode_sel = 2'd3; restart(); clear();
    mem_addr_blk_wr_start = 16'h0800; mem_addr_blk_wr_end = 16'h0801;
    chain(0, 0, 1'b0, 32'h80001000, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL and_notag got %b want 0", indirect_protect_active); end
    chain(0, 0, 1'b1, 32'h80002000, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL and_norange got %b want 0", indirect_protect_active); end
    chain(0, 0, 1'b1, 32'h80001000, 1'b0);
    tests++; if (indirect_protect_active !== 1'b1) begin errors++; $display("FAIL and_both got %b want 1", indirect_protect_active); end
    mode_sel = 2'd2;
    chain(0, 0, 1'b0, 32'h80001000, 1'b0);
    tests++; if (indirect_protect_active !== 1'b1) begin errors++; $display("FAIL or_range got %b want 1", indirect_protect_active); end
    tests++; if (detect_count !== 8'h02) begin errors++; $display("FAIL and_or_count got %h want 02", detect_count); end
  endtask

  task automatic test_gap();
    mode_sel = 2'd0; restart(); clear();
    chain(2, 2, 1'b1, 32'h0, 1'b0);
    tests++; if (indirect_protect_active !== 1'b1) begin errors++; $display("FAIL gap2_flag got %b want 1", indirect_protect_active); end
    exec(LW1, '0, '0, 1'b0, 1'b0);
    exec(LW2, '0, '0, 1'b0, 1'b0);
    exec(LW3, '0, '0, 1'b0, 1'b0);
    tests++; if (state_dbg !== 2'd3) begin errors++; $display("FAIL gap3_store got %0d want 3", state_dbg); end
    exec(NOP, '0, '0, 1'b0, 1'b0);
    exec(NOP, '0, '0, 1'b0, 1'b0);
    tests++; if (state_dbg !== 2'd3) begin errors++; $display("FAIL gap3_hold got %0d want 3", state_dbg); end
    exec(NOP, '0, '0, 1'b0, 1'b0);
    tests++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL gap3_state got %0d want 0", state_dbg); end
    exec(SW, '0, {1'b1, 32'h0}, 1'b0, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL gap3_flag got %b want 0", indirect_protect_active); end
  endtask

  task automatic test_abort();
    mode_sel = 2'd0; restart(); clear();
    exec(LW1, '0, '0, 1'b0, 1'b0);
    exec(LW2, '0, '0, 1'b0, 1'b0);
    tests++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL abort_aux got %0d want 2", state_dbg); end
    exec(ADDI, '0, '0, 1'b0, 1'b0);
    tests++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state got %0d want 0", state_dbg); end
    exec(LW3, '0, '0, 1'b0, 1'b0);
    exec(SW, '0, {1'b1, 32'h0}, 1'b0, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL abort_flag got %b want 0", indirect_protect_active); end
    tests++; if (detect_count !== 8'h00) begin errors++; $display("FAIL abort_count got %h want 00", detect_count); end
  endtask

  task automatic test_exception();
    mode_sel = 2'd0; restart(); clear();
    exec(LW1, '0, '0, 1'b0, 1'b0);
    exec(LW2, '0, '0, 1'b0, 1'b0);
    exec(LW3, '0, '0, 1'b1, 1'b0);
    tests++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL exc_ignored got %0d want 2", state_dbg); end
    exec(SW, '0, {1'b1, 32'h0}, 1'b0, 1'b0);
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL exc_flag got %b want 0", indirect_protect_active); end
    tests++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL exc_state got %0d want 2", state_dbg); end
  endtask

  task automatic test_saturation();
    mode_sel = 2'd0; restart(); clear();
    for (int i = 0; i < 256; i++) chain(0, 0, 1'b1, 32'h0, 1'b0);
    tests++; if (detect_count !== 8'hFF) begin errors++; $display("FAIL sat_count got %h want ff", detect_count); end
    chain(0, 0, 1'b1, 32'h0, 1'b1);
    tests++; if (detect_count !== 8'h01) begin errors++; $display("FAIL clr_hit_count got %h want 01", detect_count); end
    tests++; if (protect_sticky !== 1'b1) begin errors++; $display("FAIL clr_hit_sticky got %b want 1", protect_sticky); end
    clear();
    tests++; if (detect_count !== 8'h00) begin errors++; $display("FAIL clr_count got %h want 00", detect_count); end
    tests++; if (protect_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %b want 0", protect_sticky); end
  endtask

  task automatic test_reset_mid();
    mode_sel = 2'd0; restart();
    chain(0, 0, 1'b1, 32'h0, 1'b0);
    exec(LW1, '0, '0, 1'b0, 1'b0);
    exec(LW2, '0, '0, 1'b0, 1'b0);
    #2 reset_n = 1'b0; #1;
    tests++; if (indirect_protect_active !== 1'b0) begin errors++; $display("FAIL mid_flag got %b want 0", indirect_protect_active); end
    tests++; if (protect_sticky !== 1'b0) begin errors++; $display("FAIL mid_sticky got %b want 0", protect_sticky); end
    tests++; if (detect_count !== 8'h00) begin errors++; $display("FAIL mid_count got %h want 00", detect_count); end
    tests++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL mid_state got %0d want 0", state_dbg); end
    @(negedge clk); reset_n = 1'b1; @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; exe_enable = 1'b0; exception_handler_active = 1'b0;
    clear_stats = 1'b0; IR_in = NOP; rs1_in_copy = '0; rs2_in_copy = '0; mode_sel = 2'd0;
    mem_addr_blk_wr_start = 16'h0; mem_addr_blk_wr_end = 16'h0;
    test_reset();
    test_tag_mode();
    test_range_mode();
    test_mode_and();
    test_gap();
    test_abort();
    test_exception();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
